write_arbiter: RTL

WRITE_ARBITER -- requirements
Module: write_arbiter

---
 rtl/write_arbiter_pkg.sv | 32 +++
 rtl/write_arbiter_wb_queue.sv | 106 ++++++++++
 rtl/write_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/write_arbiter_pkg.sv
// ============================================================================
//  Module   : write_arbiter_pkg
//  Purpose  : Shared widths, queue entry layout and helpers for write_arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package write_arbiter_pkg;

    localparam int LEN_PREG_ADDR = 6;
    localparam int LEN_WORD      = 32;
    localparam int LEN_CONTEXT   = 4;
    localparam int LEN_WB_ENTRY  = LEN_PREG_ADDR + LEN_WORD + LEN_CONTEXT;

    typedef struct packed {
        logic [LEN_PREG_ADDR-1:0] pa_rd;
        logic [LEN_WORD-1:0]      d_rd;
        logic [LEN_CONTEXT-1:0]   ctx;
    } wb_entry_t;

    // True when a squash is requested and the entry shares any squashed context.
    function automatic logic hazard_hit(
        input logic                   hazard,
        input logic [LEN_CONTEXT-1:0] entry_ctx,
        input logic [LEN_CONTEXT-1:0] hazard_ctx
    );
        return hazard && (|(entry_ctx & hazard_ctx));
    endfunction

endpackage

`default_nettype wire

// File: rtl/write_arbiter_wb_queue.sv
// ============================================================================
//  Module   : wb_queue
//  Purpose  : Circular write-back result buffer, 2 push ports, 1 pop per cycle.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module wb_queue
    import write_arbiter_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    push0,
    input  logic [LEN_WB_ENTRY-1:0] push0_entry,
    input  logic                    push1,
    input  logic [LEN_WB_ENTRY-1:0] push1_entry,
    input  logic                    branch_hazard,
    input  logic [LEN_CONTEXT-1:0]  hazard_context,
    input  logic [LEN_CONTEXT-1:0]  safe_context,
    output logic                    head_valid,
    output logic [LEN_WB_ENTRY-1:0] head_entry,
    output logic [CNT_W-1:0]        count
);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
            $error("wb_queue DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic                  valid_q [DEPTH];
    wb_entry_t             entry_q [DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [PTR_W-1:0]      tail_p1;
    logic [PTR_W-1:0]      tail_next;
    logic [CNT_W-1:0]      n_push;
    logic                  pop;
    wb_entry_t             in0;
    wb_entry_t             in1;

    assign pop     = (count != '0);
    assign tail_p1 = tail + PTR_W'(1);
    assign n_push  = CNT_W'(push0) + CNT_W'(push1);

    always_comb begin
        tail_next = tail;
        if (push0 && push1) begin
            tail_next = tail + PTR_W'(2);
        end else if (push0) begin
            tail_next = tail_p1;
        end
    end

    // Incoming entries get the same safe-context clearing as stored ones.
    always_comb begin
        in0     = push0_entry;
        in1     = push1_entry;
        in0.ctx = in0.ctx & ~safe_context;
        in1.ctx = in1.ctx & ~safe_context;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                entry_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (hazard_hit(branch_hazard, entry_q[i].ctx, hazard_context)) begin
                    valid_q[i] <= 1'b0;
                end
                entry_q[i].ctx <= entry_q[i].ctx & ~safe_context;
            end
            if (pop) begin
                valid_q[head] <= 1'b0;
                head          <= head + PTR_W'(1);
            end
            // Push slots are always free: the grant limit never exceeds DEPTH - count.
            if (push0) begin
                valid_q[tail] <= 1'b1;
                entry_q[tail] <= in0;
            end
            if (push1) begin
                valid_q[tail_p1] <= 1'b1;
                entry_q[tail_p1] <= in1;
            end
            tail  <= tail_next;
            count <= count + n_push - CNT_W'(pop);
        end
    end

    assign head_valid = valid_q[head];
    assign head_entry = entry_q[head];

endmodule

`default_nettype wire

// File: rtl/write_arbiter.sv
// ============================================================================
//  Module   : write_arbiter
//  Purpose  : Grants up to two result sources per cycle into a write-back queue.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module write_arbiter
    import write_arbiter_pkg::*;
#(
    parameter int N_SRC = 3,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [N_SRC-1:0]               src_order,
    input  logic [N_SRC*LEN_PREG_ADDR-1:0] src_pa_rd,
    input  logic [N_SRC*LEN_WORD-1:0]      src_d_rd,
    input  logic [N_SRC*LEN_CONTEXT-1:0]   src_context,
    output logic [N_SRC-1:0]               src_accepted,
    output logic                           w1_order,
    output logic [LEN_PREG_ADDR-1:0]       w1_pa_rd,
    output logic [LEN_WORD-1:0]            w1_d_rd,
    input  logic                           branch_hazard,
    input  logic [LEN_CONTEXT-1:0]         hazard_context,
    input  logic [LEN_CONTEXT-1:0]         safe_context,
    output logic                           empty
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        free_slots;
    logic [1:0]              grant_limit;
    logic [1:0]              granted;
    logic                    push0;
    logic                    push1;
    wb_entry_t               push0_entry;
    wb_entry_t               push1_entry;
    wb_entry_t               cand;
    logic                    head_valid;
    wb_entry_t               head_fields;
    logic                    busy;

    // Free space is judged on the count at cycle start; the same-cycle pop is ignored.
    assign free_slots  = CNT_W'(DEPTH) - count;
    assign grant_limit = (free_slots >= CNT_W'(2)) ? 2'd2 : free_slots[1:0];

    always_comb begin
        granted      = '0;
        src_accepted = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (rstn && src_order[i] && (granted < grant_limit)) begin
                src_accepted[i] = 1'b1;
                granted         = granted + 2'd1;
            end
        end
    end

    // Zero-address and squashed results are taken but dropped; survivors pack into push0 first.
    always_comb begin
        push0       = 1'b0;
        push1       = 1'b0;
        push0_entry = '0;
        push1_entry = '0;
        cand        = '0;
        for (int i = 0; i < N_SRC; i++) begin
            cand.pa_rd = src_pa_rd[i*LEN_PREG_ADDR +: LEN_PREG_ADDR];
            cand.d_rd  = src_d_rd[i*LEN_WORD +: LEN_WORD];
            cand.ctx   = src_context[i*LEN_CONTEXT +: LEN_CONTEXT];
            if (src_accepted[i] && (cand.pa_rd != '0) &&
                !hazard_hit(branch_hazard, cand.ctx, hazard_context)) begin
                if (!push0) begin
                    push0       = 1'b1;
                    push0_entry = cand;
                end else begin
                    push1       = 1'b1;
                    push1_entry = cand;
                end
            end
        end
    end

    wb_queue #(
        .DEPTH (DEPTH)
    ) u_wb_queue (
        .clk            (clk),
        .rstn           (rstn),
        .push0          (push0),
        .push0_entry    (push0_entry),
        .push1          (push1),
        .push1_entry    (push1_entry),
        .branch_hazard  (branch_hazard),
        .hazard_context (hazard_context),
        .safe_context   (safe_context),
        .head_valid     (head_valid),
        .head_entry     (head_fields),
        .count          (count)
    );

    assign busy     = (count != '0);
    assign empty    = !busy;
    assign w1_order = busy && head_valid &&
                      !hazard_hit(branch_hazard, head_fields.ctx, hazard_context);
    assign w1_pa_rd = busy ? head_fields.pa_rd : '0;
    assign w1_d_rd  = busy ? head_fields.d_rd  : '0;

endmodule

`default_nettype wire
